// File: rtl/seg7_pkg.sv
// Shared constants and the BCD-to-segment decode for the multiplexed counter display.
// Segment patterns are {a,b,c,d,e,f,g}, active low.
package seg7_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } count_dir_e;

    localparam logic [3:0] BCD_MAX   = 4'd9;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;

    // A corrupted (non-BCD) digit shows as "0" rather than garbage.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_0;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_decade.sv
// One BCD decade of the up/down counter; carry_out feeds the step of the next decade.
module bcd_decade
    import seg7_pkg::*;
(
    input  logic       clock_100Mhz,
    input  logic       reset,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] load_digit,
    input  logic       step,
    input  logic       up_down,
    output logic [3:0] digit,
    output logic       carry_out
);

    logic [3:0] r_digit;
    logic       w_at_limit;

    // Digit sits at the wrap point for the current direction
    always_comb begin
        if (up_down == DIR_UP) begin
            w_at_limit = (r_digit == BCD_MAX);
        end else begin
            w_at_limit = (r_digit == 4'd0);
        end
    end

    assign carry_out = step && w_at_limit;

    // Digit register, priority reset > clear > load > step > hold
    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            r_digit <= 4'd0;
        end else if (clear) begin
            r_digit <= 4'd0;
        end else if (load) begin
            r_digit <= (load_digit > BCD_MAX) ? 4'd0 : load_digit;
        end else if (step) begin
            if (up_down == DIR_UP) begin
                r_digit <= w_at_limit ? 4'd0 : r_digit + 4'd1;
            end else begin
                r_digit <= w_at_limit ? BCD_MAX : r_digit - 4'd1;
            end
        end else begin
            r_digit <= r_digit;
        end
    end

    assign digit = r_digit;

endmodule

// File: rtl/bcd_counter_mux_display.sv
// Multi-decade up/down BCD counter driving a time-multiplexed common-anode 7-segment display.
module bcd_counter_mux_display
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 100_000_000,
    parameter int SCAN_DIV   = 100_000,
    parameter int BLANK_LZ   = 0
) (
    input  logic                    clock_100Mhz,
    input  logic                    reset,
    input  logic                    count_en,
    input  logic                    up_down,
    input  logic                    clear,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    output logic [4*NUM_DIGITS-1:0] bcd_value,
    output logic                    rollover,
    output logic [NUM_DIGITS-1:0]   Anode_Activate,
    output logic [6:0]              LED_out
);

    localparam int PRESC_W = $clog2(TICK_DIV);
    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [PRESC_W-1:0]      r_presc;
    logic [SCAN_W-1:0]       r_scan_cnt;
    logic [IDX_W-1:0]        r_scan_idx;
    logic                    r_rollover;
    logic [NUM_DIGITS-1:0]   r_anode;
    logic [6:0]              r_led;
    logic                    w_presc_last;
    logic                    w_tick;
    logic                    w_top_carry;
    logic [4*NUM_DIGITS-1:0] w_bcd;
    logic [3:0]              w_sel_digit;
    logic                    w_sel_blank;
    logic                    w_zero_run;

    assign w_presc_last = (r_presc == PRESC_W'(TICK_DIV - 1));
    assign w_tick       = w_presc_last && count_en;

    // Count-rate prescaler; frozen with the count when count_en is low
    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            r_presc <= {PRESC_W{1'b0}};
        end else if (clear) begin
            r_presc <= {PRESC_W{1'b0}};
        end else if (count_en) begin
            r_presc <= w_presc_last ? {PRESC_W{1'b0}} : r_presc + PRESC_W'(1);
        end else begin
            r_presc <= r_presc;
        end
    end

    genvar gi;
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_decade
        logic w_step_in;
        logic w_carry;
        if (gi == 0) begin : g_first
            assign w_step_in = w_tick;
        end else begin : g_next
            assign w_step_in = g_decade[gi-1].w_carry;
        end
        bcd_decade u_decade (
            .clock_100Mhz (clock_100Mhz),
            .reset        (reset),
            .clear        (clear),
            .load         (load),
            .load_digit   (load_value[4*gi +: 4]),
            .step         (w_step_in),
            .up_down      (up_down),
            .digit        (w_bcd[4*gi +: 4]),
            .carry_out    (w_carry)
        );
    end

    assign w_top_carry = g_decade[NUM_DIGITS-1].w_carry;

    // Wrap pulse coincides with the first cycle the wrapped value is visible
    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            r_rollover <= 1'b0;
        end else if (clear || load) begin
            r_rollover <= 1'b0;
        end else begin
            r_rollover <= w_top_carry;
        end
    end

    // Free-running digit scan, independent of the count enable
    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            r_scan_cnt <= {SCAN_W{1'b0}};
            r_scan_idx <= {IDX_W{1'b0}};
        end else if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            r_scan_cnt <= {SCAN_W{1'b0}};
            r_scan_idx <= (r_scan_idx == IDX_W'(NUM_DIGITS - 1)) ? {IDX_W{1'b0}}
                                                                : r_scan_idx + IDX_W'(1);
        end else begin
            r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
            r_scan_idx <= r_scan_idx;
        end
    end

    // Pick the scanned digit; walking down from the top tracks whether all digits so far are zero
    always_comb begin
        w_sel_digit = 4'd0;
        w_sel_blank = 1'b0;
        w_zero_run  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zero_run = w_zero_run && (w_bcd[4*i +: 4] == 4'd0);
            if (IDX_W'(i) == r_scan_idx) begin
                w_sel_digit = w_bcd[4*i +: 4];
                w_sel_blank = (BLANK_LZ != 0) && (i != 0) && w_zero_run;
            end else begin
                w_sel_digit = w_sel_digit;
                w_sel_blank = w_sel_blank;
            end
        end
    end

    // Display output registers
    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            r_anode <= {NUM_DIGITS{1'b1}};
            r_led   <= SEG_BLANK;
        end else begin
            r_anode <= ~(NUM_DIGITS'(1'b1) << r_scan_idx);
            r_led   <= w_sel_blank ? SEG_BLANK : bcd_to_seg(w_sel_digit);
        end
    end

    assign bcd_value      = w_bcd;
    assign rollover       = r_rollover;
    assign Anode_Activate = r_anode;
    assign LED_out        = r_led;

endmodule

// File: tb/tb_bcd_counter_mux_display.sv
// Directed bench: two instances (no blanking / leading-zero blanking) share one stimulus stream.
module tb_bcd_counter_mux_display;

    logic        clk = 1'b0;
    logic        reset, count_en, up_down, clear, load;
    logic [15:0] load_value;
    logic [15:0] bcd_a, bcd_b;
    logic        ro_a, ro_b;
    logic [3:0]  an_a, an_b;
    logic [6:0]  led_a, led_b;
    int          passed = 0;
    int          total  = 0;

    always #5 clk = ~clk;

    bcd_counter_mux_display #(.NUM_DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2), .BLANK_LZ(0)) dut_a (
        .clock_100Mhz(clk), .reset(reset), .count_en(count_en), .up_down(up_down),
        .clear(clear), .load(load), .load_value(load_value), .bcd_value(bcd_a),
        .rollover(ro_a), .Anode_Activate(an_a), .LED_out(led_a));

    bcd_counter_mux_display #(.NUM_DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2), .BLANK_LZ(1)) dut_b (
        .clock_100Mhz(clk), .reset(reset), .count_en(count_en), .up_down(up_down),
        .clear(clear), .load(load), .load_value(load_value), .bcd_value(bcd_b),
        .rollover(ro_b), .Anode_Activate(an_b), .LED_out(led_b));

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance to the first sample of scan slot 0 (anode 1110 right after 0111)
    task automatic sync_slot0(output logic ok);
        int n;
        n = 0;
        while (an_a != 4'b0111 && n < 40) begin
            step(1);
            n++;
        end
        while (an_a == 4'b0111 && n < 40) begin
            step(1);
            n++;
        end
        ok = (an_a == 4'b1110) && (n < 40);
    endtask

    initial begin
        logic       ok;
        logic [3:0] exp_an  [4];
        logic [6:0] exp_la  [4];
        logic [6:0] exp_lb  [4];

        exp_an[0] = 4'b1110; exp_an[1] = 4'b1101; exp_an[2] = 4'b1011; exp_an[3] = 4'b0111;

        reset = 1'b1; count_en = 1'b0; up_down = 1'b1; clear = 1'b0; load = 1'b0;
        load_value = 16'h0000;
        step(3);
        chk("rst_bcd", bcd_a, 16'h0000);
        chk("rst_ro", {15'd0, ro_a}, 16'h0000);
        chk("rst_an", {12'd0, an_a}, 16'h000F);
        chk("rst_led", {9'd0, led_a}, 16'h007F);

        // 1: count up, one step every 4 clocks
        reset = 1'b0; count_en = 1'b1; up_down = 1'b1;
        step(3);  chk("up_e3", bcd_a, 16'h0000);
        step(1);  chk("up_e4", bcd_a, 16'h0001);
        step(31); chk("up_e35", bcd_a, 16'h0008);
        step(1);  chk("up_e36", bcd_a, 16'h0009);
        step(3);  chk("up_e39", bcd_a, 16'h0009);
        step(1);  chk("up_e40", bcd_a, 16'h0010);
        chk("up_ro", {15'd0, ro_a}, 16'h0000);
        count_en = 1'b0;

        // 2: load 9999, up tick wraps with a single-cycle rollover
        load = 1'b1; load_value = 16'h9999;
        step(1);  chk("ld_9999", bcd_a, 16'h9999);
        load = 1'b0; count_en = 1'b1;
        step(3);  chk("wrap_pre", bcd_a, 16'h9999);
        chk("wrap_pre_ro", {15'd0, ro_a}, 16'h0000);
        step(1);  chk("wrap_bcd", bcd_a, 16'h0000);
        chk("wrap_ro", {15'd0, ro_a}, 16'h0001);
        step(1);  chk("wrap_ro_off", {15'd0, ro_a}, 16'h0000);
        count_en = 1'b0;
        load = 1'b1; load_value = 16'h00F3;
        step(1);  chk("ld_nonbcd", bcd_a, 16'h0003);
        chk("ld_ro", {15'd0, ro_a}, 16'h0000);
        load = 1'b0;

        // 3: clear then count down through the borrow wrap
        clear = 1'b1;
        step(1);  chk("clr_bcd", bcd_a, 16'h0000);
        clear = 1'b0; up_down = 1'b0; count_en = 1'b1;
        step(3);  chk("dn_pre", bcd_a, 16'h0000);
        step(1);  chk("dn_wrap", bcd_a, 16'h9999);
        chk("dn_ro", {15'd0, ro_a}, 16'h0001);
        step(1);  chk("dn_ro_off", {15'd0, ro_a}, 16'h0000);
        step(3);  chk("dn_9998", bcd_a, 16'h9998);
        chk("dn_9998_ro", {15'd0, ro_a}, 16'h0000);

        // 4: clear colliding with a tick, then count_en freeze
        step(3);  chk("coll_pre", bcd_a, 16'h9998);
        clear = 1'b1; up_down = 1'b1;
        step(1);  chk("coll_bcd", bcd_a, 16'h0000);
        chk("coll_ro", {15'd0, ro_a}, 16'h0000);
        clear = 1'b0;
        step(3);  chk("coll_e3", bcd_a, 16'h0000);
        step(1);  chk("coll_e4", bcd_a, 16'h0001);
        count_en = 1'b0;
        step(10); chk("hold_bcd", bcd_a, 16'h0001);
        count_en = 1'b1;
        step(3);  chk("hold_e3", bcd_a, 16'h0001);
        step(1);  chk("hold_e4", bcd_a, 16'h0002);
        count_en = 1'b0;

        // 5: scan of 1234
        load = 1'b1; load_value = 16'h1234;
        step(1);
        load = 1'b0;
        sync_slot0(ok);
        chk("scan_sync", {15'd0, ok}, 16'h0001);
        exp_la[0] = 7'b1001100; exp_la[1] = 7'b0000110; exp_la[2] = 7'b0010010; exp_la[3] = 7'b1001111;
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("scan_an_%0d", c), {12'd0, an_a}, {12'd0, exp_an[c/2]});
            chk($sformatf("scan_led_%0d", c), {9'd0, led_a}, {9'd0, exp_la[c/2]});
            chk($sformatf("scan_ledb_%0d", c), {9'd0, led_b}, {9'd0, exp_la[c/2]});
            step(1);
        end

        // 6: leading-zero blanking on 0042, then on 0
        load = 1'b1; load_value = 16'h0042;
        step(1);
        load = 1'b0;
        sync_slot0(ok);
        chk("blk_sync", {15'd0, ok}, 16'h0001);
        exp_la[0] = 7'b0010010; exp_la[1] = 7'b1001100; exp_la[2] = 7'b0000001; exp_la[3] = 7'b0000001;
        exp_lb[0] = 7'b0010010; exp_lb[1] = 7'b1001100; exp_lb[2] = 7'b1111111; exp_lb[3] = 7'b1111111;
        for (int c = 0; c < 8; c += 2) begin
            chk($sformatf("blk_an_%0d", c), {12'd0, an_b}, {12'd0, exp_an[c/2]});
            chk($sformatf("blk_leda_%0d", c), {9'd0, led_a}, {9'd0, exp_la[c/2]});
            chk($sformatf("blk_ledb_%0d", c), {9'd0, led_b}, {9'd0, exp_lb[c/2]});
            step(2);
        end
        load = 1'b1; load_value = 16'h0000;
        step(1);
        load = 1'b0;
        sync_slot0(ok);
        chk("zero_sync", {15'd0, ok}, 16'h0001);
        exp_lb[0] = 7'b0000001; exp_lb[1] = 7'b1111111; exp_lb[2] = 7'b1111111; exp_lb[3] = 7'b1111111;
        for (int c = 0; c < 8; c += 2) begin
            chk($sformatf("zero_ledb_%0d", c), {9'd0, led_b}, {9'd0, exp_lb[c/2]});
            step(2);
        end

        // Reset in the middle of a scan slot and while counting
        load = 1'b1; load_value = 16'h0505;
        step(1);
        load = 1'b0; count_en = 1'b1;
        step(3);
        reset = 1'b1;
        step(1);
        chk("mid_rst_bcd_a", bcd_a, 16'h0000);
        chk("mid_rst_bcd_b", bcd_b, 16'h0000);
        chk("mid_rst_ro", {15'd0, ro_a}, 16'h0000);
        chk("mid_rst_an_a", {12'd0, an_a}, 16'h000F);
        chk("mid_rst_an_b", {12'd0, an_b}, 16'h000F);
        chk("mid_rst_led_a", {9'd0, led_a}, 16'h007F);
        chk("mid_rst_led_b", {9'd0, led_b}, 16'h007F);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
